// File: rtl/nock_increment.sv
// Nock opcode-4 unit: fetch the operand (inline atom or pointed-to atom), add one,
// overwrite the execute node with the resulting atom, and hand control back to traversal.
module nock_increment #(
   parameter int ADDR_W = 10,
   parameter int NOUN_W = 28,
   parameter int TAG_W  = 8,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              execute,
   input  logic [ADDR_W-1:0] module_address_in,
   input  logic [DATA_W-1:0] module_data_in,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] read_data1,
   output logic              mem_execute,
   output logic [ADDR_W-1:0] address1,
   output logic [1:0]        mem_func,
   output logic [DATA_W-1:0] write_data,
   output logic [ADDR_W-1:0] module_address,
   output logic              module_finished,
   output logic [3:0]        execute_return_sys_func,
   output logic [3:0]        execute_return_state,
   output logic [7:0]        error
);
   // state     | meaning
   // S_IDLE    | waiting for execute select; latch node
   // S_DECODE  | check opcode, pick inline or pointed-to operand
   // S_RD_REQ  | read strobe for operand node
   // S_RD_WAIT | wait for read data, reject cells
   // S_INCR    | overflow check, form result
   // S_WR_REQ  | write strobe, node becomes atom
   // S_WR_WAIT | wait for write completion
   // S_DONE    | one-cycle finish pulse with return func/state
   // S_HOLD    | wait for select to drop before re-arming
   typedef enum logic [3:0] {
      S_IDLE, S_DECODE, S_RD_REQ, S_RD_WAIT, S_INCR, S_WR_REQ, S_WR_WAIT, S_DONE, S_HOLD
   } state_t;

   localparam logic [1:0] GET_CONTENTS = 2'b01;
   localparam logic [1:0] SET_CONTENTS = 2'b10;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   node_addr_q, node_addr_d;
   logic [DATA_W-1:0]   node_data_q, node_data_d;
   logic [NOUN_W-1:0]   operand_q, operand_d;
   logic [7:0]          error_q, error_d;

   logic                mem_execute_q, mem_execute_d;
   logic [ADDR_W-1:0]   address1_q, address1_d;
   logic [1:0]          mem_func_q, mem_func_d;
   logic [DATA_W-1:0]   write_data_q, write_data_d;
   logic [ADDR_W-1:0]   module_address_q, module_address_d;
   logic                finished_q, finished_d;
   logic [3:0]          ret_func_q, ret_func_d;
   logic [3:0]          ret_state_q, ret_state_d;

   logic [TAG_W-1:0]    node_tag;
   logic [NOUN_W-1:0]   node_hed, node_tel, rd_hed;
   logic [1:0]          rd_tag_cells;

   assign node_tag     = node_data_q[DATA_W-1 -: TAG_W];
   assign node_hed     = node_data_q[2*NOUN_W-1:NOUN_W];
   assign node_tel     = node_data_q[NOUN_W-1:0];
   assign rd_hed       = read_data1[2*NOUN_W-1:NOUN_W];
   assign rd_tag_cells = read_data1[DATA_W-TAG_W +: 2];

   always_comb begin
      state_d     = state_q;
      node_addr_d = node_addr_q;
      node_data_d = node_data_q;
      operand_d   = operand_q;
      error_d     = error_q;
      case (state_q)
         S_IDLE: begin
            if (execute) begin
               node_addr_d = module_address_in;
               node_data_d = module_data_in;
               error_d     = 8'd0;
               state_d     = S_DECODE;
            end
         end
         S_DECODE: begin
            if (node_hed != NOUN_W'(4)) begin
               error_d = 8'd1;
               state_d = S_DONE;
            end else if (!node_tag[0]) begin
               operand_d = node_tel;
               state_d   = S_INCR;
            end else begin
               state_d = S_RD_REQ;
            end
         end
         S_RD_REQ: state_d = S_RD_WAIT;
         S_RD_WAIT: begin
            if (mem_ready) begin
               if (rd_tag_cells != 2'b00) begin
                  error_d = 8'd2;
                  state_d = S_DONE;
               end else begin
                  operand_d = rd_hed;
                  state_d   = S_INCR;
               end
            end
         end
         S_INCR: begin
            if (operand_q == {NOUN_W{1'b1}}) begin
               error_d = 8'd3;
               state_d = S_DONE;
            end else begin
               state_d = S_WR_REQ;
            end
         end
         S_WR_REQ:  state_d = S_WR_WAIT;
         S_WR_WAIT: if (mem_ready) state_d = S_DONE;
         S_DONE:    state_d = S_HOLD;
         S_HOLD: begin
            if (!execute) begin
               error_d = 8'd0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Losing the select mid-operation abandons the node silently.
      if (!execute && state_q != S_IDLE && state_q != S_HOLD) begin
         error_d = 8'd0;
         state_d = S_IDLE;
      end
   end

   // Outputs are decoded from the next state so they are registered yet aligned with it.
   always_comb begin
      mem_execute_d    = 1'b0;
      address1_d       = '0;
      mem_func_d       = 2'b00;
      write_data_d     = '0;
      module_address_d = '0;
      finished_d       = 1'b0;
      ret_func_d       = 4'h0;
      ret_state_d      = 4'h0;
      if (state_d == S_RD_REQ) begin
         mem_execute_d = 1'b1;
         mem_func_d    = GET_CONTENTS;
         address1_d    = node_tel[ADDR_W-1:0];
      end
      if (state_d == S_WR_REQ) begin
         mem_execute_d = 1'b1;
         mem_func_d    = SET_CONTENTS;
         address1_d    = node_addr_q;
         write_data_d[2*NOUN_W-1:NOUN_W] = operand_q + NOUN_W'(1);
      end
      if (state_d == S_DONE || state_d == S_HOLD) begin
         module_address_d = node_addr_q;
         if (error_d != 8'd0) begin
            ret_func_d  = 4'h3;
            ret_state_d = 4'hF;
         end
      end
      finished_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= S_IDLE;
         node_addr_q      <= '0;
         node_data_q      <= '0;
         operand_q        <= '0;
         error_q          <= 8'd0;
         mem_execute_q    <= 1'b0;
         address1_q       <= '0;
         mem_func_q       <= 2'b00;
         write_data_q     <= '0;
         module_address_q <= '0;
         finished_q       <= 1'b0;
         ret_func_q       <= 4'h0;
         ret_state_q      <= 4'h0;
      end else begin
         state_q          <= state_d;
         node_addr_q      <= node_addr_d;
         node_data_q      <= node_data_d;
         operand_q        <= operand_d;
         error_q          <= error_d;
         mem_execute_q    <= mem_execute_d;
         address1_q       <= address1_d;
         mem_func_q       <= mem_func_d;
         write_data_q     <= write_data_d;
         module_address_q <= module_address_d;
         finished_q       <= finished_d;
         ret_func_q       <= ret_func_d;
         ret_state_q      <= ret_state_d;
      end
   end

   assign mem_execute             = mem_execute_q;
   assign address1                = address1_q;
   assign mem_func                = mem_func_q;
   assign write_data              = write_data_q;
   assign module_address          = module_address_q;
   assign module_finished         = finished_q;
   assign execute_return_sys_func = ret_func_q;
   assign execute_return_state    = ret_state_q;
   assign error                   = error_q;
endmodule

// File: tb/tb_nock_increment.sv
// Scoreboard bench for nock_increment: expected reads, writes and completions are
// queued when a node is issued and popped as the DUT strobes memory or finishes.
module tb_nock_increment;
   localparam logic [1:0] GET_CONTENTS = 2'b01;
   localparam logic [1:0] SET_CONTENTS = 2'b10;

   typedef struct {
      logic [9:0]  addr;
      logic [63:0] data;
   } wr_t;
   typedef struct {
      logic [9:0] addr;
      logic [3:0] func;
      logic [3:0] st;
      logic [7:0] err;
   } fin_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        execute = 1'b0;
   logic [9:0]  module_address_in = '0;
   logic [63:0] module_data_in = '0;
   logic        mem_ready = 1'b0;
   logic [63:0] read_data1 = '0;
   logic        mem_execute;
   logic [9:0]  address1;
   logic [1:0]  mem_func;
   logic [63:0] write_data;
   logic [9:0]  module_address;
   logic        module_finished;
   logic [3:0]  execute_return_sys_func;
   logic [3:0]  execute_return_state;
   logic [7:0]  error;

   int n_vec = 0;
   int n_err = 0;
   int rd_lat = 1;
   int wr_lat = 1;
   int fin_seen = 0;
   logic prev_strobe = 1'b0;
   logic [63:0] mem [0:1023];
   logic [9:0]  exp_rd_q [$];
   wr_t         exp_wr_q [$];
   fin_t        exp_fin_q [$];

   nock_increment dut (
      .clk(clk), .rst(rst), .execute(execute),
      .module_address_in(module_address_in), .module_data_in(module_data_in),
      .mem_ready(mem_ready), .read_data1(read_data1),
      .mem_execute(mem_execute), .address1(address1), .mem_func(mem_func),
      .write_data(write_data), .module_address(module_address),
      .module_finished(module_finished),
      .execute_return_sys_func(execute_return_sys_func),
      .execute_return_state(execute_return_state), .error(error)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] mk(input logic [7:0] tag, input logic [27:0] hed,
                                      input logic [27:0] tel);
      return {tag, hed, tel};
   endfunction

   // Memory model: answers each strobe after rd_lat/wr_lat cycles.
   always begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (mem_execute && !rst) begin
         logic [1:0]  f;
         logic [9:0]  a;
         logic [63:0] d;
         f = mem_func;
         a = address1;
         d = write_data;
         if (f == SET_CONTENTS) begin
            if (exp_wr_q.size() == 0) check_eq("unexpected_write", 1, 0);
            else begin
               wr_t w;
               w = exp_wr_q.pop_front();
               check_eq("wr_addr", a, w.addr);
               check_eq("wr_data", d, w.data);
            end
            mem[a] = d;
            repeat (wr_lat) @(negedge clk);
         end else begin
            check_eq("rd_func", f, GET_CONTENTS);
            if (exp_rd_q.size() == 0) check_eq("unexpected_read", 1, 0);
            else check_eq("rd_addr", a, exp_rd_q.pop_front());
            repeat (rd_lat) @(negedge clk);
            read_data1 = mem[a];
         end
         mem_ready = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (mem_execute) check_eq("strobe_one_cycle", prev_strobe, 0);
      prev_strobe = mem_execute;
      if (module_finished) begin
         fin_seen++;
         if (exp_fin_q.size() == 0) check_eq("unexpected_finish", 1, 0);
         else begin
            fin_t e;
            e = exp_fin_q.pop_front();
            check_eq("fin_addr", module_address, e.addr);
            check_eq("fin_func", execute_return_sys_func, e.func);
            check_eq("fin_state", execute_return_state, e.st);
            check_eq("fin_error", error, e.err);
         end
      end
   end

   task automatic push_fin(input logic [9:0] a, input logic [7:0] err);
      fin_t f;
      f.addr = a;
      f.err  = err;
      f.func = (err == 0) ? 4'h0 : 4'h3;
      f.st   = (err == 0) ? 4'h0 : 4'hF;
      exp_fin_q.push_back(f);
   endtask

   task automatic push_wr(input logic [9:0] a, input logic [63:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      exp_wr_q.push_back(w);
   endtask

   // Latency counts the edge that samples execute through the edge that samples the pulse.
   task automatic run(input logic [63:0] node, input logic [9:0] a, input int exp_lat,
                      input int hold_cyc, input logic [7:0] hold_err);
      int lat;
      bit done;
      @(negedge clk);
      module_address_in = a;
      module_data_in    = node;
      execute           = 1'b1;
      lat  = 1;
      done = 0;
      while (!done && lat < 80) begin
         @(negedge clk);
         lat++;
         if (module_finished) done = 1;
      end
      if (!done) check_eq("finish_timeout", 1, 0);
      else check_eq("latency", lat, exp_lat);
      repeat (hold_cyc) @(negedge clk);
      if (hold_cyc > 0) begin
         check_eq("hold_no_pulse", module_finished, 0);
         check_eq("hold_error", error, hold_err);
      end
      execute = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("idle_error", error, 0);
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_mem_execute"}, mem_execute, 0);
      check_eq({tag, "_mem_func"}, mem_func, 0);
      check_eq({tag, "_address1"}, address1, 0);
      check_eq({tag, "_write_data"}, write_data, 0);
      check_eq({tag, "_module_address"}, module_address, 0);
      check_eq({tag, "_finished"}, module_finished, 0);
      check_eq({tag, "_error"}, error, 0);
      check_eq({tag, "_ret_func"}, execute_return_sys_func, 0);
      check_eq({tag, "_ret_state"}, execute_return_state, 0);
   endtask

   initial begin
      int fin_before;
      int budget;
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_idle_outputs("reset");

      // Direct atom 41 -> 42
      wr_lat = 1;
      push_wr(10'h010, mk(8'h00, 42, 0));
      push_fin(10'h010, 0);
      run(mk(8'h80, 4, 41), 10'h010, 6, 0, 0);

      // Pointer operand 99 -> 100, Lr=3 Lw=1
      mem[10'h020] = mk(8'h00, 99, 0);
      rd_lat = 3;
      exp_rd_q.push_back(10'h020);
      push_wr(10'h010, mk(8'h00, 100, 0));
      push_fin(10'h010, 0);
      run(mk(8'h81, 4, 28'h020), 10'h010, 10, 0, 0);

      // Operand is a cell
      mem[10'h020] = mk(8'h03, 7, 9);
      exp_rd_q.push_back(10'h020);
      push_fin(10'h010, 2);
      run(mk(8'h81, 4, 28'h020), 10'h010, 7, 0, 0);

      // Overflow on direct atom
      push_fin(10'h044, 3);
      run(mk(8'h80, 4, 28'hFFFFFFF), 10'h044, 4, 0, 0);

      // Wrong opcode, select held long after the finish pulse
      push_fin(10'h055, 1);
      run(mk(8'h80, 5, 41), 10'h055, 3, 12, 1);

      // Re-armed after select low: direct atom at a different node, held too
      wr_lat = 2;
      push_wr(10'h030, mk(8'h00, 28'h0ABCDEF, 0));
      push_fin(10'h030, 0);
      run(mk(8'h80, 4, 28'h0ABCDEE), 10'h030, 7, 6, 0);

      // Drop execute while waiting on the read
      rd_lat = 5;
      mem[10'h020] = mk(8'h00, 5, 0);
      exp_rd_q.push_back(10'h020);
      fin_before = fin_seen;
      @(negedge clk);
      module_address_in = 10'h011;
      module_data_in    = mk(8'h81, 4, 28'h020);
      execute           = 1'b1;
      repeat (3) @(negedge clk);
      execute = 1'b0;
      repeat (15) @(negedge clk);
      check_eq("abort_no_finish", fin_seen, fin_before);
      check_idle_outputs("abort");

      // Reset during the write wait
      wr_lat = 6;
      push_wr(10'h012, mk(8'h00, 8, 0));
      fin_before = fin_seen;
      @(negedge clk);
      module_address_in = 10'h012;
      module_data_in    = mk(8'h80, 4, 7);
      execute           = 1'b1;
      budget = 0;
      while (!mem_execute && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      if (!mem_execute) check_eq("write_strobe_timeout", 1, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_idle_outputs("midreset");
      rst     = 1'b0;
      execute = 1'b0;
      repeat (12) @(negedge clk);
      check_eq("reset_no_finish", fin_seen, fin_before);

      // Clean run after reset
      wr_lat = 1;
      push_wr(10'h013, mk(8'h00, 1, 0));
      push_fin(10'h013, 0);
      run(mk(8'h80, 4, 0), 10'h013, 6, 0, 0);

      repeat (4) @(negedge clk);
      check_eq("rd_q_drained", exp_rd_q.size(), 0);
      check_eq("wr_q_drained", exp_wr_q.size(), 0);
      check_eq("fin_q_drained", exp_fin_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/nock_increment.md
# nock_increment

Nock opcode-4 (increment) execution unit. Sits directly downstream of `mem_traversal`: when traversal finds a fully-visited execute node whose hed is opcode 4, it selects this unit via `mux_controller == MUX_INCR` and passes the node address and word. The unit:

- fetches the operand;
- increments it;
- overwrites the node with the resulting atom;
- returns control to traversal with a return function/state.

## Interface

Parameters:
- `ADDR_W`, default 10: memory address width. `10'd1023` is NIL.
- `NOUN_W`, default 28: hed/tel field width.
- `TAG_W`, default 8: tag width.
- `DATA_W`, default 64: memory word width, `{tag, hed, tel}`.

Ports:
- `clk`  in  1: clock. This is the only clock.
- `rst`  in  1: reset. Synchronous, active-high.
- `execute`  in  1: select level. High while `mux_controller == MUX_INCR`.
- `module_address_in`  in  ADDR_W: address of the node being executed.
- `module_data_in`  in  DATA_W: node word `{tag, hed, tel}`.
- `mem_ready`  in  1: memory operation complete. `read_data1` is valid in the same cycle.
- `read_data1`  in  DATA_W: read data.
- `mem_execute`  out  1: single-cycle memory request strobe.
- `address1`  out  ADDR_W: request address.
- `mem_func`  out  2: `GET_CONTENTS` or `SET_CONTENTS`. Zero when idle.
- `write_data`  out  DATA_W: data for `SET_CONTENTS`.
- `module_address`  out  ADDR_W: address handed back to traversal.
- `module_finished`  out  1: single-cycle completion pulse.
- `execute_return_sys_func`  out  4: traversal function to resume in.
- `execute_return_state`  out  4: traversal state to resume in.
- `error`  out  8: 0 = ok, 1 = opcode is not 4, 2 = operand is a cell, 3 = overflow.

## Operation

Tag encoding:
- `tag[1]` = hed is a cell; `tag[0]` = tel is a cell.
- `tag[3:2]` = visited bits; `tag[7]` = execute-pending bit.

States: IDLE, DECODE, RD_REQ, RD_WAIT, INCR, WR_REQ, WR_WAIT, DONE, HOLD.

- **IDLE**: when `execute == 1`, latch `module_address_in` and `module_data_in`, then go to DECODE.
- **DECODE**:
  - If hed ≠ 4, set `error = 1` and go to DONE.
  - Else if `tag[0] == 0` (tel is a direct atom), operand = tel; go to INCR.
  - Else go to RD_REQ.
- **RD_REQ**: drive `address1` = tel, `mem_func = GET_CONTENTS`, `mem_execute = 1` for one cycle. Go to RD_WAIT.
- **RD_WAIT**: drive `mem_execute`/`mem_func` to 0. Hold until `mem_ready`. Then:
  - If `read_data1.tag[1:0] != 2'b00`, set `error = 2` and go to DONE.
  - Else operand = `read_data1` hed; go to INCR.
- **INCR**:
  - If operand == `{NOUN_W{1'b1}}`, set `error = 3` and go to DONE. There is no wrap and no bignum.
  - Else result = operand + 1 (NOUN_W bits). Go to WR_REQ.
- **WR_REQ**: one-cycle strobe with `address1` = latched node address, `mem_func = SET_CONTENTS`. `write_data = {8'h00, result, NOUN_W'(0)}`, i.e. tag ATOM_ATOM, unvisited, execute bit cleared; tel = 0. Go to WR_WAIT.
- **WR_WAIT**: clear strobe. Go to DONE on `mem_ready`.
- **DONE**: pulse `module_finished = 1` for exactly one cycle and set `module_address` = latched node address.
  - With `error == 0`: return func = `4'h0` (READ), state = `4'h0` (READ_INIT). Traversal re-reads the rewritten node, sees ATOM_ATOM, and pops.
  - With `error != 0`: return func = `4'h3` (EXECUTE), state = `4'hF` (EXECUTE_ERROR). Memory is untouched.
  - Go to HOLD.
- **HOLD**: wait for `execute == 0`, then go to IDLE and clear `error`. This prevents re-trigger on a stale select.

Further rules:
- If `execute` drops in any state other than IDLE or HOLD, abort to IDLE: no strobe, no `module_finished`. A write already strobed is not retracted.
- `mem_ready` outside RD_WAIT/WR_WAIT is ignored.

## Timing

- Reset values (also the idle values):
  - `mem_execute`, `mem_func`, `address1`, `write_data`, `module_address`, `module_finished`, `error`, `execute_return_sys_func`, `execute_return_state` = 0.
  - FSM = IDLE.
- `mem_execute` is high for exactly one cycle per request; at most one request is outstanding.
- Latency from `execute` rising to `module_finished`, with memory latency Lr/Lw cycles (strobe to `mem_ready`):
  - direct atom: 5 + Lw;
  - pointer operand: 6 + Lr + Lw;
  - opcode error: 3;
  - overflow on direct atom: 4.
- All outputs are registered; there are no combinational input-to-output paths.
- `rst` asserted mid-operation returns the FSM to IDLE on the next edge and forces all outputs to reset values. An in-flight memory op is abandoned.

## Test plan

- Direct atom: node `{8'h80, hed=4, tel=41}` at 0x010, Lw = 1.
  - One write to 0x010 with data `{8'h00, 42, 0}`.
  - `module_finished` pulse with return 0/0, `module_address = 0x010`, `error = 0`.
- Pointer operand: tel = 0x020 with `tag[0] = 1`; memory[0x020] = `{00, 99, 0}`; Lr = 3.
  - Read of 0x020, then write of `{00, 100, 0}` to the node.
  - Latency 6 + 3 + Lw.
- Cell operand: memory[0x020] tag = 2'b11.
  - `error = 2`, return 3/F, no write strobe.
- Overflow: tel = 0xFFFFFFF.
  - `error = 3`, no write.
  - Wrong opcode (hed = 5): `error = 1` after 3 cycles.
- Select handling:
  - Hold `execute` high after `module_finished`: exactly one pulse; the unit re-arms only after `execute` goes low.
  - Drop `execute` in RD_WAIT: returns to IDLE with no finish pulse.
- Reset: assert `rst` in WR_WAIT.
  - All outputs are 0 next cycle.
  - A subsequent clean run completes normally.
